// File: rtl/blink_counter_core_pkg.sv
// Shared mode and direction encodings for the blink counter.
package blink_pkg;

    typedef enum logic [1:0] {
        MODE_UP      = 2'd0,
        MODE_DOWN    = 2'd1,
        MODE_BOUNCE  = 2'd2,
        MODE_ONESHOT = 2'd3
    } mode_t;

    localparam logic DIR_UP = 1'b0;
    localparam logic DIR_DN = 1'b1;

endpackage

// File: rtl/blink_counter_core_if.sv
// Control/status bundle between the tt_um wrapper and the blink counter core.
interface blink_counter_core_if #(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 4
);
    logic                  en;
    logic [1:0]            mode;
    logic                  load;
    logic [WIDTH-1:0]      load_val;
    logic [PRESCALE_W-1:0] div;
    logic [WIDTH-1:0]      cnt;
    logic                  tc;
    logic                  dir;
    logic                  busy;

    modport master (
        output en, mode, load, load_val, div,
        input  cnt, tc, dir, busy
    );

    modport slave (
        input  en, mode, load, load_val, div,
        output cnt, tc, dir, busy
    );
endinterface

// File: rtl/blink_counter_core_prescaler.sv
// Clock-enable prescaler: one tick every div+1 enabled cycles, restartable by clr.
module blink_prescaler #(
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  clr,
    input  logic [PRESCALE_W-1:0] div,
    output logic                  tick
);
    localparam logic [PRESCALE_W-1:0] ONE = {{(PRESCALE_W-1){1'b0}}, 1'b1};

    logic [PRESCALE_W-1:0] presc;

    // >= rather than == so lowering div below presc cannot strand the counter.
    assign tick = en && (presc >= div);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc <= '0;
        end else if (clr) begin
            presc <= '0;
        end else if (en) begin
            presc <= tick ? '0 : presc + ONE;
        end
    end
endmodule

// File: rtl/blink_counter_core.sv
// Multi-mode blink counter: up/down/bounce/one-shot with load, tc pulse and status.
import blink_pkg::*;

module blink_counter_core #(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 4
) (
    input logic                clk,
    input logic                rst_n,
    blink_counter_core_if.slave bus
);
    localparam logic [WIDTH-1:0] MAX    = '1;
    localparam logic [WIDTH-1:0] ONE    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MAX_M1 = MAX - ONE;

    logic             tick;
    mode_t            mode;
    logic [WIDTH-1:0] cnt_q, cnt_d, cnt_inc, cnt_dec;
    logic             dir_q, dir_d;
    logic             tc_q, tc_d;
    logic             busy_q, busy_d;

    assign mode    = mode_t'(bus.mode);
    assign cnt_inc = cnt_q + ONE;
    assign cnt_dec = cnt_q - ONE;

    blink_prescaler #(.PRESCALE_W(PRESCALE_W)) u_presc (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (bus.en),
        .clr   (bus.load),
        .div   (bus.div),
        .tick  (tick)
    );

    always_comb begin
        cnt_d  = cnt_q;
        dir_d  = dir_q;
        tc_d   = 1'b0;
        busy_d = busy_q;
        if (bus.load) begin
            cnt_d  = bus.load_val;
            dir_d  = DIR_UP;
            busy_d = (mode == MODE_ONESHOT) && (bus.load_val != MAX);
        end else if (tick) begin
            // A pending one-shot is abandoned once another mode takes a tick.
            if (mode != MODE_ONESHOT) busy_d = 1'b0;
            unique case (mode)
                MODE_UP: begin
                    cnt_d = cnt_inc;
                    dir_d = DIR_UP;
                    tc_d  = (cnt_q == MAX);
                end
                MODE_DOWN: begin
                    cnt_d = cnt_dec;
                    dir_d = DIR_DN;
                    tc_d  = (cnt_q == '0);
                end
                MODE_BOUNCE: begin
                    if (dir_q == DIR_UP) begin
                        if (cnt_q == MAX) begin
                            cnt_d = MAX_M1;
                            dir_d = DIR_DN;
                            tc_d  = 1'b1;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        if (cnt_q == '0) begin
                            cnt_d = ONE;
                            dir_d = DIR_UP;
                            tc_d  = 1'b1;
                        end else begin
                            cnt_d = cnt_dec;
                        end
                    end
                end
                MODE_ONESHOT: begin
                    if (busy_q) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == MAX) begin
                            busy_d = 1'b0;
                            tc_d   = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            dir_q  <= DIR_UP;
            tc_q   <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            dir_q  <= dir_d;
            tc_q   <= tc_d;
            busy_q <= busy_d;
        end
    end

    assign bus.cnt  = cnt_q;
    assign bus.dir  = dir_q;
    assign bus.tc   = tc_q;
    assign bus.busy = busy_q;
endmodule

// File: tb/tb_blink_counter_core.sv
// Scoreboard bench: 8-bit and 3-bit cores share stimulus, each against an arithmetic model.
module tb_blink_counter_core;

    typedef struct {
        int cnt;
        int tc;
        int dir;
        int busy;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       load;
    logic [1:0] mode;
    logic [7:0] lv;
    logic [3:0] div;

    int checks   = 0;
    int failures = 0;

    exp_t q8[$];
    exp_t q3[$];

    int mx[2]      = '{255, 7};
    int m_cnt[2]   = '{0, 0};
    int m_presc[2] = '{0, 0};
    int m_dir[2]   = '{0, 0};
    int m_tc[2]    = '{0, 0};
    int m_busy[2]  = '{0, 0};

    blink_counter_core_if #(.WIDTH(8), .PRESCALE_W(4)) bus8 ();
    blink_counter_core_if #(.WIDTH(3), .PRESCALE_W(4)) bus3 ();

    assign bus8.en       = en;
    assign bus8.mode     = mode;
    assign bus8.load     = load;
    assign bus8.load_val = lv;
    assign bus8.div      = div;
    assign bus3.en       = en;
    assign bus3.mode     = mode;
    assign bus3.load     = load;
    assign bus3.load_val = lv[2:0];
    assign bus3.div      = div;

    blink_counter_core #(.WIDTH(8), .PRESCALE_W(4)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    blink_counter_core #(.WIDTH(3), .PRESCALE_W(4)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, req);
        end
    endtask

    // Reference behaviour for one clock, from the current inputs.
    task automatic model_step(input int k);
        int  md, lvk, nxt;
        bit  tick;
        md  = int'(mode);
        lvk = int'(lv) % (mx[k] + 1);
        if (!rst_n) begin
            m_cnt[k] = 0; m_presc[k] = 0; m_dir[k] = 0; m_tc[k] = 0; m_busy[k] = 0;
        end else if (load) begin
            m_cnt[k]   = lvk;
            m_presc[k] = 0;
            m_dir[k]   = 0;
            m_tc[k]    = 0;
            m_busy[k]  = (md == 3 && lvk != mx[k]) ? 1 : 0;
        end else begin
            tick = en && (m_presc[k] >= int'(div));
            if (en) m_presc[k] = tick ? 0 : m_presc[k] + 1;
            m_tc[k] = 0;
            if (tick) begin
                if (md != 3) m_busy[k] = 0;
                case (md)
                    0: begin
                        m_tc[k]  = (m_cnt[k] == mx[k]) ? 1 : 0;
                        m_cnt[k] = (m_cnt[k] + 1) % (mx[k] + 1);
                        m_dir[k] = 0;
                    end
                    1: begin
                        m_tc[k]  = (m_cnt[k] == 0) ? 1 : 0;
                        m_cnt[k] = (m_cnt[k] + mx[k]) % (mx[k] + 1);
                        m_dir[k] = 1;
                    end
                    2: begin
                        nxt = (m_dir[k] == 1) ? m_cnt[k] - 1 : m_cnt[k] + 1;
                        if (nxt < 0 || nxt > mx[k]) begin
                            m_dir[k] = 1 - m_dir[k];
                            nxt      = (m_dir[k] == 1) ? mx[k] - 1 : 1;
                            m_tc[k]  = 1;
                        end
                        m_cnt[k] = nxt;
                    end
                    default: begin
                        if (m_busy[k] == 1) begin
                            m_cnt[k] = (m_cnt[k] + 1) % (mx[k] + 1);
                            if (m_cnt[k] == mx[k]) begin
                                m_busy[k] = 0;
                                m_tc[k]   = 1;
                            end
                        end
                    end
                endcase
            end
        end
    endtask

    task automatic step();
        exp_t e;
        model_step(0);
        e = '{cnt: m_cnt[0], tc: m_tc[0], dir: m_dir[0], busy: m_busy[0]};
        q8.push_back(e);
        model_step(1);
        e = '{cnt: m_cnt[1], tc: m_tc[1], dir: m_dir[1], busy: m_busy[1]};
        q3.push_back(e);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q8.size() > 0) begin
            e = q8.pop_front();
            chk("cnt8",  32'(bus8.cnt),  e.cnt);
            chk("tc8",   32'(bus8.tc),   e.tc);
            chk("dir8",  32'(bus8.dir),  e.dir);
            chk("busy8", 32'(bus8.busy), e.busy);
        end
        if (q3.size() > 0) begin
            e = q3.pop_front();
            chk("cnt3",  32'(bus3.cnt),  e.cnt);
            chk("tc3",   32'(bus3.tc),   e.tc);
            chk("dir3",  32'(bus3.dir),  e.dir);
            chk("busy3", 32'(bus3.busy), e.busy);
        end
    end

    initial begin
        #300000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; en = 1'b0; load = 1'b0; mode = 2'd0; lv = 8'h00; div = 4'd3;
        repeat (2) step();

        // UP with div=3 through the 255->0 wrap
        rst_n = 1'b1; en = 1'b1;
        repeat (1030) step();

        // DOWN from 2 across the 0->MAX wrap, then en gating
        div = 4'd0; mode = 2'd1; load = 1'b1; lv = 8'h02; step();
        load = 1'b0; repeat (4) step();
        en = 1'b0; repeat (5) step();
        en = 1'b1; repeat (4) step();

        // load collides with a tick at 0xFF
        mode = 2'd0; div = 4'd3; load = 1'b1; lv = 8'hFF; step();
        load = 1'b0; repeat (3) step();
        load = 1'b1; lv = 8'h40; step();
        load = 1'b0; repeat (9) step();

        // BOUNCE descending to 0x80, reset, then bounce from reset
        mode = 2'd2; div = 4'd0; load = 1'b1; lv = 8'hFE; step();
        load = 1'b0; repeat (128) step();
        rst_n = 1'b0; step();
        rst_n = 1'b1; repeat (20) step();

        // ONESHOT from 5, hold at MAX, reload at MAX
        mode = 2'd3; load = 1'b1; lv = 8'h05; step();
        load = 1'b0; repeat (14) step();
        load = 1'b1; lv = 8'h07; step();
        load = 1'b0; repeat (3) step();

        repeat (3000) begin
            rst_n = ($urandom_range(0, 199) != 0);
            en    = ($urandom_range(0, 7) != 0);
            load  = ($urandom_range(0, 29) == 0);
            lv    = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
            if ($urandom_range(0, 49) == 0) mode = 2'($urandom);
            if ($urandom_range(0, 99) == 0) div = 4'($urandom_range(0, 5));
            step();
        end

        rst_n = 1'b1; load = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("drain", 32'(q8.size() + q3.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
